// File: rtl/ceespu_dmem_pkg.sv
// ceespu_dmem_pkg: shared types and constants for the ceespu data-memory controller.
//   state_e   : controller FSM states (IDLE, WAIT)
//   DEF_*     : default memory-map decode constants
//   ERR_DATA  : read data returned when an external access is aborted
package ceespu_dmem_pkg;
    typedef enum logic {IDLE, WAIT} state_e;
    localparam int          DEF_RAM_WORDS = 4096;
    localparam logic [15:0] DEF_EXT_BASE  = 16'h8000;
    localparam logic [31:0] ERR_DATA      = 32'hDEADBEEF;
endpackage

// File: rtl/ceespu_dmem_ram.sv
// ceespu_dmem_ram: single-port synchronous RAM, WORDS x 32, byte write-enables, write-first.
//   clk_i   : clock
//   en_i    : access enable
//   we_i    : byte write-enables (all zero = read)
//   addr_i  : word address
//   wdata_i : store data
//   rdata_o : registered read data; on a write it shows the merged new word
module ceespu_dmem_ram
    import ceespu_dmem_pkg::*;
#(
    parameter int WORDS = DEF_RAM_WORDS
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic [3:0]               we_i,
    input  logic [$clog2(WORDS)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);
    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;
    logic [31:0] word_d;
    always_comb begin
        word_d = mem_q[addr_i];
        for (int b = 0; b < 4; b++) word_d[8*b +: 8] = we_i[b] ? wdata_i[8*b +: 8] : mem_q[addr_i][8*b +: 8];
    end
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (|we_i) mem_q[addr_i] <= word_d;
            rdata_q <= word_d;
        end
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/ceespu_dmem_ctrl.sv
// ceespu_dmem_ctrl: data-memory responder for the ceespu core dmem port
module ceespu_dmem_ctrl
  import ceespu_dmem_pkg::*;
#(
  parameter int          RAM_WORDS = DEF_RAM_WORDS,
  parameter logic [15:0] EXT_BASE  = DEF_EXT_BASE,
  parameter int          TIMEOUT   = 255
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [15:0] I_dmemAddress,
  input  logic [31:0] I_dmemWData,
  input  logic        I_dmemE,
  input  logic [3:0]  I_dmemWe,
  output logic [31:0] O_dmemData,
  output logic        O_dmemBusy,
  output logic        O_extReq,
  output logic [15:0] O_extAddr,
  output logic [31:0] O_extWData,
  output logic [3:0]  O_extBe,
  output logic        O_extWr,
  input  logic        I_extAck,
  input  logic [31:0] I_extRData,
  output logic        O_busErr
);
  localparam int AW = $clog2(RAM_WORDS);
  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic [31:0] data_q, data_d;
  logic        sel_q, sel_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wr_q, wr_d;
  logic        ram_en;
  logic [31:0] ram_rdata;
  logic        is_int, is_ext, is_rd;
`ifdef CEESPU_DMEM_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
`endif
  assign is_int = {16'd0, I_dmemAddress} < 32'(RAM_WORDS * 4);
  assign is_ext = I_dmemAddress >= EXT_BASE;
  assign is_rd  = ~|I_dmemWe;
  ceespu_dmem_ram #(.WORDS(RAM_WORDS)) u_ram (
    .clk_i   (I_clk),
    .en_i    (ram_en),
    .we_i    (I_dmemWe),
    .addr_i  (I_dmemAddress[AW+1:2]),
    .wdata_i (I_dmemWData),
    .rdata_o (ram_rdata)
  );
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    data_d  = data_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    ram_en  = 1'b0;
`ifdef CEESPU_DMEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    if (state_q == IDLE) begin
      if (I_dmemE && is_int) begin
        ram_en = 1'b1;
        if (is_rd) sel_d = 1'b1;
        else if (sel_q) begin
          data_d = ram_rdata;
          sel_d  = 1'b0;
        end
      end else if (I_dmemE && is_ext) begin
        state_d = WAIT;
        busy_d  = 1'b1;
        addr_d  = I_dmemAddress;
        wdata_d = I_dmemWData;
        be_d    = I_dmemWe;
        wr_d    = ~is_rd;
`ifdef CEESPU_DMEM_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end else if (I_dmemE && is_rd) begin
        data_d = 32'd0;
        sel_d  = 1'b0;
      end
    end else if (I_extAck) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      if (!wr_q) begin
        data_d = I_extRData;
        sel_d  = 1'b0;
      end
    end
`ifdef CEESPU_DMEM_TIMEOUT_EN
    else begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == 8'(TIMEOUT)) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        err_d   = 1'b1;
        if (!wr_q) begin
          data_d = ERR_DATA;
          sel_d  = 1'b0;
        end
      end
    end
`endif
  end
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      data_q  <= 32'd0;
      sel_q   <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      wr_q    <= 1'b0;
`ifdef CEESPU_DMEM_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
`ifdef CEESPU_DMEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end
  assign O_dmemData = sel_q ? ram_rdata : data_q;
  assign O_dmemBusy = busy_q;
  assign O_extReq   = busy_q;
  assign O_extAddr  = addr_q;
  assign O_extWData = wdata_q;
  assign O_extBe    = be_q;
  assign O_extWr    = wr_q;
`ifdef CEESPU_DMEM_TIMEOUT_EN
  assign O_busErr   = err_q;
`else
  assign O_busErr   = 1'b0;
`endif
endmodule
